// File: rtl/arcade_video_timing_if.sv
// Raster timing bundle: arcade_video_timing drives it (master); mixer and tile pipeline consume it.
// With VIDEO_TIMING_ADJ_EN defined, the slave side also supplies the signed sync shifts.
interface arcade_video_timing_if;
    logic       ce_pix;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic       HSync;
    logic       VSync;
    logic       HBlank;
    logic       VBlank;
    logic       frame;
`ifdef VIDEO_TIMING_ADJ_EN
    logic signed [3:0] h_adj;
    logic signed [3:0] v_adj;

    modport master (
        output ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame,
        input  h_adj, v_adj
    );
    modport slave (
        input  ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame,
        output h_adj, v_adj
    );
`else
    modport master (
        output ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame
    );
    modport slave (
        input  ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame
    );
`endif
endinterface

// File: rtl/arcade_video_timing.sv
// Free-running raster timing generator: pixel clock-enable, h/v counters, registered sync/blank.
// Define VIDEO_TIMING_ADJ_EN to add per-frame h_adj/v_adj sync-position shifts.
module arcade_video_timing #(
    parameter int unsigned CE_DIV       = 4,
    parameter int unsigned H_TOTAL      = 384,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned H_SYNC_START = 304,
    parameter int unsigned H_SYNC_LEN   = 32,
    parameter int unsigned V_TOTAL      = 264,
    parameter int unsigned V_ACTIVE     = 224,
    parameter int unsigned V_SYNC_START = 240,
    parameter int unsigned V_SYNC_LEN   = 4
) (
    input logic                   clk_sys,
    input logic                   reset_n,
    arcade_video_timing_if.master vid
);

    localparam int unsigned     DivW       = $clog2(CE_DIV);
    localparam logic [DivW-1:0] DivMax     = DivW'(CE_DIV - 1);
    localparam logic [8:0]      HMax       = 9'(H_TOTAL - 1);
    localparam logic [8:0]      VMax       = 9'(V_TOTAL - 1);
    localparam logic [9:0]      HActive    = 10'(H_ACTIVE);
    localparam logic [9:0]      VActive    = 10'(V_ACTIVE);
    localparam logic [9:0]      HSyncStart = 10'(H_SYNC_START);
    localparam logic [9:0]      HSyncLen   = 10'(H_SYNC_LEN);
    localparam logic [9:0]      VSyncStart = 10'(V_SYNC_START);
    localparam logic [9:0]      VSyncLen   = 10'(V_SYNC_LEN);

    if (CE_DIV < 2) begin : g_bad_ce_div
        $error("arcade_video_timing: CE_DIV must be at least 2");
    end
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("arcade_video_timing: H_TOTAL/V_TOTAL exceed the 9-bit counters");
    end
    if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL)
    begin : g_bad_sync
        $error("arcade_video_timing: sync window runs past the line/frame total");
    end
    if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_bad_active
        $error("arcade_video_timing: active area must be smaller than the total");
    end
`ifdef VIDEO_TIMING_ADJ_EN
    // A 4-bit signed shift spans -8..+7, so each sync window needs 8 units of slack each side.
    if (H_SYNC_START < 8 || H_SYNC_START + H_SYNC_LEN + 8 > H_TOTAL ||
        V_SYNC_START < 8 || V_SYNC_START + V_SYNC_LEN + 8 > V_TOTAL) begin : g_bad_margin
        $error("arcade_video_timing: sync windows need 8 units of adjust margin");
    end
`endif

    logic            run_q;
    logic [DivW-1:0] div_q, div_d;
    logic            ce_q, ce_d;
    logic [8:0]      hcnt_q, hcnt_d;
    logic [8:0]      vcnt_q, vcnt_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            hblank_q, hblank_d;
    logic            vblank_q, vblank_d;
    logic            frame_q, frame_d;
    logic            h_wrap, v_wrap;
    logic [9:0]      hs_start, hs_end;
    logic [9:0]      vs_start, vs_end;

    assign h_wrap = (hcnt_q == HMax);
    assign v_wrap = (vcnt_q == VMax);

`ifdef VIDEO_TIMING_ADJ_EN
    logic       frame_wrap;
    logic [3:0] h_adj_q, v_adj_q;

    assign frame_wrap = ce_q & h_wrap & v_wrap;

    // Shifts are latched only at the frame boundary so a frame never sees two sync positions.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_adj_q <= '0;
            v_adj_q <= '0;
        end else if (frame_wrap) begin
            h_adj_q <= vid.h_adj;
            v_adj_q <= vid.v_adj;
        end
    end

    assign hs_start = HSyncStart + {{6{h_adj_q[3]}}, h_adj_q};
    assign vs_start = VSyncStart + {{6{v_adj_q[3]}}, v_adj_q};
`else
    assign hs_start = HSyncStart;
    assign vs_start = VSyncStart;
`endif

    assign hs_end = hs_start + HSyncLen;
    assign vs_end = vs_start + VSyncLen;

    always_comb begin
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        frame_d  = frame_q;

        // run_q holds the divider for one edge after reset release, placing the
        // first ce_pix CE_DIV cycles after reset_n rises.
        if (run_q) begin
            div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
        end
        ce_d = (div_d == DivMax);

        if (ce_q) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 9'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + 9'd1;
                if (v_wrap) begin
                    frame_d = ~frame_q;
                end
            end
        end

        // Decode from next counter values so registered flags line up with the counters.
        hsync_d  = ({1'b0, hcnt_d} >= hs_start) && ({1'b0, hcnt_d} < hs_end);
        vsync_d  = ({1'b0, vcnt_d} >= vs_start) && ({1'b0, vcnt_d} < vs_end);
        hblank_d = ({1'b0, hcnt_d} >= HActive);
        vblank_d = ({1'b0, vcnt_d} >= VActive);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            ce_q     <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            div_q    <= div_d;
            ce_q     <= ce_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            frame_q  <= frame_d;
        end
    end

    assign vid.ce_pix = ce_q;
    assign vid.hcnt   = hcnt_q;
    assign vid.vcnt   = vcnt_q;
    assign vid.HSync  = hsync_q;
    assign vid.VSync  = vsync_q;
    assign vid.HBlank = hblank_q;
    assign vid.VBlank = vblank_q;
    assign vid.frame  = frame_q;

endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing: default-parameter instance against a constant vector table,
// small-parameter instance against a cycle-count arithmetic model with random reset pulses.
module tb_arcade_video_timing;

    localparam int SCD  = 3;
    localparam int SHT  = 48;
    localparam int SHA  = 24;
    localparam int SHSS = 32;
    localparam int SHSL = 4;
    localparam int SVT  = 30;
    localparam int SVA  = 10;
    localparam int SVSS = 12;
    localparam int SVSL = 3;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    arcade_video_timing_if vid_def ();
    arcade_video_timing_if vid_sml ();

    logic signed [3:0] tb_h_adj = '0;
    logic signed [3:0] tb_v_adj = '0;
`ifdef VIDEO_TIMING_ADJ_EN
    assign vid_def.h_adj = '0;
    assign vid_def.v_adj = '0;
    assign vid_sml.h_adj = tb_h_adj;
    assign vid_sml.v_adj = tb_v_adj;
`endif

    arcade_video_timing u_dut_def (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vid     (vid_def)
    );

    arcade_video_timing #(
        .CE_DIV       (SCD),
        .H_TOTAL      (SHT),
        .H_ACTIVE     (SHA),
        .H_SYNC_START (SHSS),
        .H_SYNC_LEN   (SHSL),
        .V_TOTAL      (SVT),
        .V_ACTIVE     (SVA),
        .V_SYNC_START (SVSS),
        .V_SYNC_LEN   (SVSL)
    ) u_dut_sml (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vid     (vid_sml)
    );

    int checks = 0;
    int errors = 0;
    int t      = 0;   // posedges since reset release
    int fi_prev = 0;
    int cur_h  = 0;
    int cur_v  = 0;
    int m_h    = 0;
    int m_v    = 0;

    typedef struct {
        int cyc;
        int ce;
        int hcnt;
        int vcnt;
        int hs;
        int hb;
    } vec_t;
    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0d, expected %0d", nm, t, act, exp);
        end
    endtask

    task automatic tick();
        int p;
        int fi;
        @(posedge clk_sys);
        if (reset_n) begin
            t++;
            p  = (t - 1) / SCD;
            fi = p / (SHT * SVT);
            if (fi != fi_prev) begin
                cur_h   = int'(tb_h_adj);
                cur_v   = int'(tb_v_adj);
                fi_prev = fi;
            end
        end
        @(negedge clk_sys);
    endtask

    // Expected raster state derived directly from the elapsed cycle count.
    task automatic check_model();
        int p, l, f, ce, hs, vs;
        p   = (t > 0) ? (t - 1) / SCD : 0;
        m_h = p % SHT;
        l   = p / SHT;
        m_v = l % SVT;
        f   = (l / SVT) % 2;
        ce  = (t > 0 && (t % SCD) == 0) ? 1 : 0;
        hs  = (m_h >= SHSS + cur_h && m_h < SHSS + cur_h + SHSL) ? 1 : 0;
        vs  = (m_v >= SVSS + cur_v && m_v < SVSS + cur_v + SVSL) ? 1 : 0;
        chk("ce_pix", int'(vid_sml.ce_pix), ce);
        chk("hcnt",   int'(vid_sml.hcnt),   m_h);
        chk("vcnt",   int'(vid_sml.vcnt),   m_v);
        chk("HSync",  int'(vid_sml.HSync),  hs);
        chk("VSync",  int'(vid_sml.VSync),  vs);
        chk("HBlank", int'(vid_sml.HBlank), (m_h >= SHA) ? 1 : 0);
        chk("VBlank", int'(vid_sml.VBlank), (m_v >= SVA) ? 1 : 0);
        chk("frame",  int'(vid_sml.frame),  f);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ce_pix"}, int'(vid_sml.ce_pix), 0);
        chk({tag, "_hcnt"},   int'(vid_sml.hcnt),   0);
        chk({tag, "_vcnt"},   int'(vid_sml.vcnt),   0);
        chk({tag, "_HSync"},  int'(vid_sml.HSync),  0);
        chk({tag, "_VSync"},  int'(vid_sml.VSync),  0);
        chk({tag, "_HBlank"}, int'(vid_sml.HBlank), 0);
        chk({tag, "_VBlank"}, int'(vid_sml.VBlank), 0);
        chk({tag, "_frame"},  int'(vid_sml.frame),  0);
        chk({tag, "_def_ce"}, int'(vid_def.ce_pix), 0);
        chk({tag, "_def_hc"}, int'(vid_def.hcnt),   0);
    endtask

    // Asynchronous reset pulse landing d ns after a rising edge, then clean restart.
    task automatic reset_pulse(input string tag, input int d);
        @(posedge clk_sys);
        #(d);
        reset_n = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk_sys);
        @(negedge clk_sys);
        t       = 0;
        fi_prev = 0;
        cur_h   = 0;
        cur_v   = 0;
        check_model();
        reset_n = 1'b1;
    endtask

    initial begin
        int vi;
        int hs_def_cyc;
        int vs_sml_cyc;
        int t_tog1, t_tog2;
        logic frame_prev;
        bit found;

        vecs[0]  = '{3,    0, 0,   0, 0, 0};
        vecs[1]  = '{4,    1, 0,   0, 0, 0};
        vecs[2]  = '{5,    0, 1,   0, 0, 0};
        vecs[3]  = '{8,    1, 1,   0, 0, 0};
        vecs[4]  = '{9,    0, 2,   0, 0, 0};
        vecs[5]  = '{1024, 1, 255, 0, 0, 0};
        vecs[6]  = '{1025, 0, 256, 0, 0, 1};
        vecs[7]  = '{1216, 1, 303, 0, 0, 1};
        vecs[8]  = '{1217, 0, 304, 0, 1, 1};
        vecs[9]  = '{1344, 1, 335, 0, 1, 1};
        vecs[10] = '{1345, 0, 336, 0, 0, 1};
        vecs[11] = '{1536, 1, 383, 0, 0, 1};
        vecs[12] = '{1537, 0, 0,   1, 0, 0};

        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        chk("reset_def_HSync",  int'(vid_def.HSync),  0);
        chk("reset_def_HBlank", int'(vid_def.HBlank), 0);
        chk("reset_def_frame",  int'(vid_def.frame),  0);
        reset_n = 1'b1;

        vi = 0;
        hs_def_cyc = 0;
        vs_sml_cyc = 0;
        t_tog1 = 0;
        t_tog2 = 0;
        frame_prev = 1'b0;
        for (int c = 0; c < 9000; c++) begin
            tick();
            check_model();
            if (vi < NV && t == vecs[vi].cyc) begin
                chk("def_ce_pix", int'(vid_def.ce_pix), vecs[vi].ce);
                chk("def_hcnt",   int'(vid_def.hcnt),   vecs[vi].hcnt);
                chk("def_vcnt",   int'(vid_def.vcnt),   vecs[vi].vcnt);
                chk("def_HSync",  int'(vid_def.HSync),  vecs[vi].hs);
                chk("def_HBlank", int'(vid_def.HBlank), vecs[vi].hb);
                chk("def_VSync",  int'(vid_def.VSync),  0);
                chk("def_VBlank", int'(vid_def.VBlank), 0);
                vi++;
            end
            if (t <= 1536 && vid_def.HSync) hs_def_cyc++;
            if (t <= SCD * SHT * SVT && vid_sml.VSync) vs_sml_cyc++;
            if (vid_sml.frame != frame_prev) begin
                if (t_tog1 == 0) t_tog1 = t;
                else if (t_tog2 == 0) t_tog2 = t;
                frame_prev = vid_sml.frame;
            end
`ifdef VIDEO_TIMING_ADJ_EN
            if (c == 2000) tb_h_adj = -4'sd3;
            if (c == 5000) tb_v_adj = 4'sd2;
`endif
        end
        chk("def_vectors_applied", vi, NV);
        chk("def_hsync_width_cycles", hs_def_cyc, 128);
        chk("sml_vsync_cycles", vs_sml_cyc, 432);
        chk("sml_first_frame_toggle", t_tog1, 4321);
        chk("sml_frame_period", t_tog2 - t_tog1, 4320);

        // Hit reset while both sync pulses are high.
        found = 1'b0;
        for (int k = 0; k < 6000 && !found; k++) begin
            tick();
            check_model();
            if (m_h == 33 && m_v == 13) found = 1'b1;
        end
        chk("reset_point_reached", int'(found), 1);
        chk("pre_reset_HSync", int'(vid_sml.HSync), (33 >= SHSS + cur_h &&
                                                     33 < SHSS + cur_h + SHSL) ? 1 : 0);
        reset_pulse("midsync", 2);
        for (int k = 0; k < 300; k++) begin
            tick();
            check_model();
        end

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(100, 5000));
            for (int k = 0; k < n; k++) begin
                tick();
                check_model();
`ifdef VIDEO_TIMING_ADJ_EN
                if ($urandom_range(0, 499) == 0) begin
                    tb_h_adj = 4'($urandom_range(0, 15));
                    tb_v_adj = 4'($urandom_range(0, 15));
                end
`endif
            end
            reset_pulse("rand", int'($urandom_range(1, 3)));
            for (int k = 0; k < 50; k++) begin
                tick();
                check_model();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
